// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline interlock controller for the 5-stage interrupt-capable MIPS CPU.
//
// Owns every pipeline-register enable. It arbitrates between memory wait, interrupt
// entry, load-use stall, eret and taken branches, and it sequences interrupt entry
// through RUN -> DRAIN -> VECTOR -> RUN.
//
// Ports:
//   clock, resetn        system clock and synchronous active-low reset
//   stall_req            load-use hazard detected in ID
//   branch_taken         taken branch/jump resolved in ID
//   eret                 eret decoded in ID
//   mem_wait             data memory not ready; freezes the whole pipeline
//   int_req, int_enable  level interrupt request and Status.IE
//   pc_we, pc_sel        PC write enable and source (0 seq/branch, 1 vector, 2 EPC)
//   ifid_we, ifid_flush  IF/ID write enable and NOP insert
//   idexe_bubble         NOP insert into ID/EXE
//   exemem_we            EXE/MEM and MEM/WB write enable
//   epc_we, cause_we     EPC / Cause capture pulses on interrupt entry
//   int_ack              one-cycle acknowledge to the interrupt source
//   stall_cnt            saturating count of cycles with pc_we = 0
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,  // legal range 1..15
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             eret,
    input  logic             mem_wait,
    input  logic             int_req,
    input  logic             int_enable,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             exemem_we,
    output logic             epc_we,
    output logic             cause_we,
    output logic             int_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StDrain  = 2'd1;
    localparam logic [1:0] StVector = 2'd2;

    localparam logic [1:0] PcSelSeq = 2'd0;
    localparam logic [1:0] PcSelVec = 2'd1;
    localparam logic [1:0] PcSelEpc = 2'd2;

    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             int_pending_q, int_pending_d;
    logic [CNT_W-1:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // The acknowledge cycle wins over a fresh request so the source is not
    // re-accepted in the same cycle it is acknowledged.
    assign int_pending_d = int_ack ? 1'b0 : (int_pending_q | (int_req & int_enable));

    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = PcSelSeq;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        exemem_we    = 1'b0;
        epc_we       = 1'b0;
        cause_we     = 1'b0;
        int_ack      = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;

        if (!resetn) begin
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
        end else if (mem_wait) begin
            // Whole pipeline frozen; state and drain count hold.
        end else begin
            case (state_q)
                StRun: begin
                    // Interrupt waits for a clean ID slot: no branch (no delay-slot EPC),
                    // no load-use stall and no eret in flight.
                    if (int_pending_q && !stall_req && !branch_taken && !eret) begin
                        epc_we       = 1'b1;
                        cause_we     = 1'b1;
                        ifid_flush   = 1'b1;
                        idexe_bubble = 1'b1;
                        exemem_we    = 1'b1;
                        state_d      = StDrain;
                        drain_d      = DrainInit;
                    end else if (stall_req) begin
                        idexe_bubble = 1'b1;
                        exemem_we    = 1'b1;
                    end else if (eret) begin
                        pc_sel     = PcSelEpc;
                        pc_we      = 1'b1;
                        ifid_flush = 1'b1;
                        exemem_we  = 1'b1;
                    end else begin
                        // Taken branch and plain sequential flow share the same
                        // enables; ID muxes the target in on a branch.
                        pc_we     = 1'b1;
                        ifid_we   = 1'b1;
                        exemem_we = 1'b1;
                    end
                end
                StDrain: begin
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                    exemem_we    = 1'b1;
                    // Leave when the decremented count reaches zero; the entry cycle
                    // already counted as one drain cycle.
                    if (drain_q <= 4'd1) begin
                        drain_d = 4'd0;
                        state_d = StVector;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                StVector: begin
                    pc_sel       = PcSelVec;
                    pc_we        = 1'b1;
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                    exemem_we    = 1'b1;
                    int_ack      = 1'b1;
                    state_d      = StRun;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= StRun;
            drain_q       <= 4'd0;
            int_pending_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            int_pending_q <= int_pending_d;
            if (!pc_we && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int unsigned DRAIN = 3;
    localparam int          MAX_MAIN = 65535;
    localparam int          MAX_SAT  = 15;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn, stall_req, branch_taken, eret, mem_wait, int_req, int_enable;

    logic        pc_we, ifid_we, ifid_flush, idexe_bubble, exemem_we, epc_we, cause_we, int_ack;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt;

    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idexe_bubble, s_exemem_we;
    logic        s_epc_we, s_cause_we, s_int_ack;
    logic [1:0]  s_pc_sel;
    logic [3:0]  s_stall_cnt;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .stall_req(stall_req), .branch_taken(branch_taken),
        .eret(eret), .mem_wait(mem_wait), .int_req(int_req), .int_enable(int_enable),
        .pc_we(pc_we), .pc_sel(pc_sel), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idexe_bubble(idexe_bubble), .exemem_we(exemem_we), .epc_we(epc_we),
        .cause_we(cause_we), .int_ack(int_ack), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_sat (
        .clock(clock), .resetn(resetn), .stall_req(stall_req), .branch_taken(branch_taken),
        .eret(eret), .mem_wait(mem_wait), .int_req(int_req), .int_enable(int_enable),
        .pc_we(s_pc_we), .pc_sel(s_pc_sel), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idexe_bubble(s_idexe_bubble), .exemem_we(s_exemem_we), .epc_we(s_epc_we),
        .cause_we(s_cause_we), .int_ack(s_int_ack), .stall_cnt(s_stall_cnt)
    );

    // Reference model: an interrupt in service is just a countdown of cycles to the
    // vector fetch (svc > 0 draining, svc == 0 vector cycle, svc < 0 idle).
    int m_pend, m_svc, m_cnt, m_cnt_sat;
    bit cnt_known;
    int checks, errors, cyc;
    int ack_cyc, epc_cyc;

    task automatic step(input logic r, input logic st, input logic br, input logic er,
                        input logic mw, input logic ir, input logic ie);
        logic       e_pcwe, e_ifwe, e_flush, e_bub, e_exe, e_epc, e_cause, e_ack;
        logic [1:0] e_sel;
        logic [9:0] exp_v, obs_v, obs_s;
        bit         accept;
        resetn = r; stall_req = st; branch_taken = br; eret = er;
        mem_wait = mw; int_req = ir; int_enable = ie;
        {e_pcwe, e_ifwe, e_flush, e_bub, e_exe, e_epc, e_cause, e_ack} = '0;
        e_sel  = 2'd0;
        accept = 1'b0;
        if (!r) begin
            e_flush = 1; e_bub = 1;
        end else if (mw) begin
        end else if (m_svc > 0) begin
            e_flush = 1; e_bub = 1; e_exe = 1;
        end else if (m_svc == 0) begin
            e_pcwe = 1; e_sel = 2'd1; e_flush = 1; e_bub = 1; e_exe = 1; e_ack = 1;
        end else if (m_pend != 0 && !st && !br && !er) begin
            accept = 1'b1;
            e_epc = 1; e_cause = 1; e_flush = 1; e_bub = 1; e_exe = 1;
        end else if (st) begin
            e_bub = 1; e_exe = 1;
        end else if (er) begin
            e_pcwe = 1; e_sel = 2'd2; e_flush = 1; e_exe = 1;
        end else begin
            e_pcwe = 1; e_ifwe = 1; e_exe = 1;
        end
        exp_v = {e_pcwe, e_sel, e_ifwe, e_flush, e_bub, e_exe, e_epc, e_cause, e_ack};

        @(negedge clock);
        obs_v = {pc_we, pc_sel, ifid_we, ifid_flush, idexe_bubble, exemem_we,
                 epc_we, cause_we, int_ack};
        obs_s = {s_pc_we, s_pc_sel, s_ifid_we, s_ifid_flush, s_idexe_bubble, s_exemem_we,
                 s_epc_we, s_cause_we, s_int_ack};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL outs cyc=%0d observed=%b expected=%b", cyc, obs_v, exp_v);
        end
        checks++;
        assert (obs_s === exp_v) else begin
            errors++;
            $error("FAIL outs_sat cyc=%0d observed=%b expected=%b", cyc, obs_s, exp_v);
        end
        if (cnt_known) begin
            checks++;
            assert (stall_cnt === 16'(m_cnt)) else begin
                errors++;
                $error("FAIL stall_cnt cyc=%0d observed=%0d expected=%0d", cyc, stall_cnt, m_cnt);
            end
            checks++;
            assert (s_stall_cnt === 4'(m_cnt_sat)) else begin
                errors++;
                $error("FAIL stall_cnt_sat cyc=%0d observed=%0d expected=%0d",
                       cyc, s_stall_cnt, m_cnt_sat);
            end
        end
        if (int_ack === 1'b1) ack_cyc = cyc;
        if (epc_we === 1'b1) epc_cyc = cyc;

        @(posedge clock);
        if (!r) begin
            m_pend = 0; m_svc = -1; m_cnt = 0; m_cnt_sat = 0; cnt_known = 1'b1;
        end else begin
            if (!e_pcwe) begin
                if (m_cnt < MAX_MAIN) m_cnt++;
                if (m_cnt_sat < MAX_SAT) m_cnt_sat++;
            end
            m_pend = e_ack ? 0 : ((m_pend != 0 || (ir && ie)) ? 1 : 0);
            if (!mw) begin
                if (accept) m_svc = (DRAIN > 1) ? int'(DRAIN) - 1 : 1;
                else if (m_svc > 0) m_svc--;
                else if (m_svc == 0) m_svc = -1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int t;
        int s0;
        m_pend = 0; m_svc = -1; m_cnt = 0; m_cnt_sat = 0; cnt_known = 1'b0;
        checks = 0; errors = 0; cyc = 0; ack_cyc = -1; epc_cyc = -1;

        // Reset held two cycles, then release.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use stall, eret, branch.
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        idle(1);

        // Interrupt pulse at t: ack at t+4 and three stalled cycles.
        s0 = int'(stall_cnt);
        t  = cyc;
        step(1, 0, 0, 0, 0, 1, 1);
        idle(5);
        checks++;
        assert (ack_cyc === t + 4) else begin
            errors++;
            $error("FAIL int_ack_time observed=%0d expected=%0d", ack_cyc, t + 4);
        end
        checks++;
        assert (int'(stall_cnt) - s0 === 3) else begin
            errors++;
            $error("FAIL int_stall_delta observed=%0d expected=3", int'(stall_cnt) - s0);
        end

        // Deferral behind a taken branch.
        t = cyc;
        step(1, 0, 1, 0, 0, 1, 1);
        step(1, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(5);
        checks++;
        assert (epc_cyc === t + 2) else begin
            errors++;
            $error("FAIL defer_epc_time observed=%0d expected=%0d", epc_cyc, t + 2);
        end

        // mem_wait for 4 cycles inside DRAIN delays the ack by exactly 4.
        t = cyc;
        step(1, 0, 0, 0, 0, 1, 1);
        idle(2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0, 1);
        idle(4);
        checks++;
        assert (ack_cyc === t + 8) else begin
            errors++;
            $error("FAIL wait_ack_time observed=%0d expected=%0d", ack_cyc, t + 8);
        end

        // Saturation of the 4-bit counter after 20 stalled cycles.
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0);
        checks++;
        assert (s_stall_cnt === 4'hF) else begin
            errors++;
            $error("FAIL sat_cnt observed=%0d expected=15", s_stall_cnt);
        end
        checks++;
        assert (stall_cnt === 16'd20) else begin
            errors++;
            $error("FAIL wide_cnt observed=%0d expected=20", stall_cnt);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
